// File: rtl/axi_defs.sv
// Shared AXI constants, default ids and FSM state encodings for the cache-side
// AXI arbiter.
package axi_defs;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;

  localparam int         ID_W_DEF = 4;
  localparam logic [3:0] I_ID_DEF = 4'd0;
  localparam logic [3:0] D_ID_DEF = 4'd1;

endpackage

// File: rtl/cache_axi_arbiter_if.sv
// AXI3/AXI4 read+write master bus as seen by the SoC interconnect.
interface cache_axi_arbiter_if import axi_defs::*; #(parameter int ID_W = ID_W_DEF);

  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [1:0]      arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [1:0]      awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;

  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; req[1] wins a tie unless it won last time.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_sel,
  output logic       pick
);

  logic last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last <= 1'b0;
    else if (upd)
      last <= upd_sel;
  end

  assign pick = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/cache_axi_arbiter.sv
// Merges I-cache and D-cache reads onto one AXI master and forwards D-cache
// writes under a single-outstanding write FSM.
//
// state  | meaning
// R_IDLE | no read owner; arbitrate pending cache requests
// R_ADDR | AR offered for the granted cache
// R_DATA | R beats routed to the granted cache until rlast
// W_IDLE | AW passed through from the D-cache
// W_DATA | W beats passed through until wlast
// W_RESP | B response passed through
module cache_axi_arbiter import axi_defs::*; #(
  parameter int            ID_W = ID_W_DEF,
  parameter logic [ID_W-1:0] I_ID = ID_W'(I_ID_DEF),
  parameter logic [ID_W-1:0] D_ID = ID_W'(D_ID_DEF)
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,

  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,

  input  logic [31:0] d_awaddr,
  input  logic [7:0]  d_awlen,
  input  logic [2:0]  d_awsize,
  input  logic        d_awvalid,
  output logic        d_awready,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  input  logic        d_wlast,
  input  logic        d_wvalid,
  output logic        d_wready,
  output logic        d_bvalid,
  input  logic        d_bready,

  cache_axi_arbiter_if.master axi
);

  logic [1:0] r_state;
  logic       gnt_d;
  logic       pick_d;
  logic       r_addr;
  logic       r_data;
  logic       sel_rready;
  logic [1:0] w_state;
  logic       w_idle;
  logic       w_data;
  logic       w_resp;

  assign r_addr     = (r_state == R_ADDR);
  assign r_data     = (r_state == R_DATA);
  assign sel_rready = gnt_d ? d_rready : i_rready;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst_n   (resetn),
    .req     ({d_arvalid, i_arvalid}),
    .upd     (r_addr & axi.arready),
    .upd_sel (gnt_d),
    .pick    (pick_d)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      gnt_d   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (i_arvalid || d_arvalid) begin
          gnt_d   <= pick_d;
          r_state <= R_ADDR;
        end
        R_ADDR: if (axi.arready) r_state <= R_DATA;
        R_DATA: if (axi.rvalid && sel_rready && axi.rlast) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign axi.arvalid = r_addr;
  assign axi.arid    = gnt_d ? D_ID : I_ID;
  assign axi.araddr  = gnt_d ? d_araddr : i_araddr;
  assign axi.arlen   = gnt_d ? d_arlen : i_arlen;
  assign axi.arsize  = SIZE_WORD;
  assign axi.arburst = BURST_INCR;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign i_arready   = r_addr & ~gnt_d & axi.arready;
  assign d_arready   = r_addr &  gnt_d & axi.arready;

  assign i_rdata    = axi.rdata;
  assign d_rdata    = axi.rdata;
  assign i_rlast    = axi.rlast;
  assign d_rlast    = axi.rlast;
  assign i_rvalid   = r_data & ~gnt_d & axi.rvalid;
  assign d_rvalid   = r_data &  gnt_d & axi.rvalid;
  assign axi.rready = r_data & sel_rready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state <= W_IDLE;
    end else begin
      case (w_state)
        W_IDLE: if (d_awvalid && axi.awready) w_state <= W_DATA;
        W_DATA: if (d_wvalid && axi.wready && d_wlast) w_state <= W_RESP;
        W_RESP: if (axi.bvalid && d_bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign w_idle = (w_state == W_IDLE);
  assign w_data = (w_state == W_DATA);
  assign w_resp = (w_state == W_RESP);

  // The idle-state passthrough would otherwise leak d_awvalid/awready during reset.
  assign axi.awvalid = resetn & w_idle & d_awvalid;
  assign d_awready   = resetn & w_idle & axi.awready;
  assign axi.awid    = D_ID;
  assign axi.awaddr  = d_awaddr;
  assign axi.awlen   = d_awlen;
  assign axi.awsize  = d_awsize;
  assign axi.awburst = BURST_INCR;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;

  assign axi.wvalid = w_data & d_wvalid;
  assign d_wready   = w_data & axi.wready;
  assign axi.wid    = D_ID;
  assign axi.wdata  = d_wdata;
  assign axi.wstrb  = d_wstrb;
  assign axi.wlast  = d_wlast;

  assign d_bvalid   = w_resp & axi.bvalid;
  assign axi.bready = w_resp & d_bready;

  // Single outstanding read/write: response ids and status are not needed.
  logic unused_resp;
  assign unused_resp = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: arbitration, routing, write FSM, reset.
module tb_cache_axi_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] i_araddr, d_araddr, i_rdata, d_rdata;
  logic [7:0]  i_arlen, d_arlen;
  logic        i_arvalid, d_arvalid, i_arready, d_arready;
  logic        i_rlast, d_rlast, i_rvalid, d_rvalid, i_rready, d_rready;
  logic [31:0] d_awaddr, d_wdata;
  logic [7:0]  d_awlen;
  logic [2:0]  d_awsize;
  logic [3:0]  d_wstrb;
  logic        d_awvalid, d_awready, d_wlast, d_wvalid, d_wready, d_bvalid, d_bready;

  int checks = 0;
  int errors = 0;
  int wbeat, rbeat, rv_seen, wb_seen, wl_seen;

  cache_axi_arbiter_if axi ();

  cache_axi_arbiter dut (
    .clk(clk), .resetn(resetn),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize), .d_awvalid(d_awvalid),
    .d_awready(d_awready), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast),
    .d_wvalid(d_wvalid), .d_wready(d_wready), .d_bvalid(d_bvalid), .d_bready(d_bready),
    .axi(axi.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0;
    i_araddr = '0; i_arlen = '0; i_arvalid = 0; i_rready = 0;
    d_araddr = '0; d_arlen = '0; d_arvalid = 0; d_rready = 0;
    d_awaddr = '0; d_awlen = '0; d_awsize = '0; d_awvalid = 0;
    d_wdata = '0; d_wstrb = '0; d_wlast = 0; d_wvalid = 0; d_bready = 0;
    axi.arready = 0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 0;
    axi.rvalid = 0; axi.awready = 0; axi.wready = 0; axi.bid = '0; axi.bresp = '0;
    axi.bvalid = 0;

    // reset: all valids/readies low even with upstream/downstream signals high
    d_awvalid = 1; d_wvalid = 1; d_rready = 1; i_rready = 1; d_bready = 1;
    axi.awready = 1; axi.wready = 1; axi.rvalid = 1; axi.bvalid = 1; axi.arready = 1;
    repeat (3) tick();
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("rst_rready", axi.rready, 0);
    chk("rst_bready", axi.bready, 0);
    chk("rst_i_arready", i_arready, 0);
    chk("rst_d_arready", d_arready, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_d_awready", d_awready, 0);
    chk("rst_d_wready", d_wready, 0);
    chk("rst_d_bvalid", d_bvalid, 0);
    d_awvalid = 0; d_wvalid = 0; d_rready = 0; i_rready = 0; d_bready = 0;
    axi.awready = 0; axi.wready = 0; axi.rvalid = 0; axi.bvalid = 0; axi.arready = 0;
    resetn = 1'b1;

    // first tie: data cache wins
    tick();
    i_arvalid = 1; i_araddr = 32'h0000_1000; i_arlen = 8'd0;
    d_arvalid = 1; d_araddr = 32'h0000_2000; d_arlen = 8'd0;
    #1 chk("tie1_not_yet", axi.arvalid, 0);
    tick();
    chk("tie1_arvalid", axi.arvalid, 1);
    chk("tie1_arid", axi.arid, 1);
    chk("tie1_araddr", axi.araddr, 32'h0000_2000);
    chk("tie1_arlen", axi.arlen, 0);
    chk("arsize", axi.arsize, 3'b010);
    chk("arburst", axi.arburst, 2'b01);
    chk("ar_lock_cache_prot", {axi.arlock, axi.arcache, axi.arprot}, 0);
    chk("tie1_d_arready_wait", d_arready, 0);
    axi.arready = 1;
    #1 chk("tie1_d_arready", d_arready, 1);
    chk("tie1_i_arready", i_arready, 0);
    tick();
    d_arvalid = 0; axi.arready = 0;
    axi.rvalid = 1; axi.rlast = 1; axi.rdata = 32'hCAFE_0001; d_rready = 1; i_rready = 1;
    #1 chk("tie1_d_rvalid", d_rvalid, 1);
    chk("tie1_i_rvalid", i_rvalid, 0);
    chk("tie1_d_rdata", d_rdata, 32'hCAFE_0001);
    chk("tie1_i_rdata_fanout", i_rdata, 32'hCAFE_0001);
    chk("tie1_d_rlast", d_rlast, 1);
    chk("tie1_rready", axi.rready, 1);
    chk("tie1_no_ar_in_data", axi.arvalid, 0);
    tick();

    // second tie: instruction cache wins
    axi.rvalid = 0; axi.rlast = 0;
    d_arvalid = 1; d_araddr = 32'h1FC0_0040; d_arlen = 8'd7;
    #1 chk("tie2_idle", axi.arvalid, 0);
    tick();
    chk("tie2_arvalid", axi.arvalid, 1);
    chk("tie2_arid", axi.arid, 0);
    chk("tie2_araddr", axi.araddr, 32'h0000_1000);
    axi.arready = 1;
    #1 chk("tie2_i_arready", i_arready, 1);
    chk("tie2_d_arready", d_arready, 0);
    tick();
    i_arvalid = 0; axi.arready = 0;

    // i refill in progress while d waits
    for (int k = 0; k < 2; k++) begin
      axi.rvalid = 1; axi.rdata = 32'hB000_0000 + k; axi.rlast = (k == 1);
      #1 chk("irefill_i_rvalid", i_rvalid, 1);
      chk("irefill_d_rvalid", d_rvalid, 0);
      chk("irefill_i_rdata", i_rdata, 32'hB000_0000 + k);
      chk("irefill_i_rlast", i_rlast, (k == 1));
      chk("irefill_d_arready", d_arready, 0);
      chk("irefill_arvalid", axi.arvalid, 0);
      tick();
    end
    axi.rvalid = 0; axi.rlast = 0;
    #1 chk("dwait_idle_arvalid", axi.arvalid, 0);
    chk("dwait_idle_d_arready", d_arready, 0);
    tick();
    chk("dgrant_arvalid", axi.arvalid, 1);
    chk("dgrant_arid", axi.arid, 1);
    chk("dgrant_araddr", axi.araddr, 32'h1FC0_0040);
    chk("dgrant_arlen", axi.arlen, 7);
    axi.arready = 1;
    tick();
    d_arvalid = 0; axi.arready = 0;

    // AW with W data offered early; read waits in R_DATA
    d_awvalid = 1; d_awaddr = 32'h3000_0100; d_awlen = 8'd7; d_awsize = 3'b010;
    d_wvalid = 1; d_wdata = 32'hD000_0000; d_wstrb = 4'hF; d_wlast = 0; axi.wready = 1;
    #1 chk("aw_awvalid", axi.awvalid, 1);
    chk("aw_awid", axi.awid, 1);
    chk("aw_awaddr", axi.awaddr, 32'h3000_0100);
    chk("aw_awlen", axi.awlen, 7);
    chk("aw_awsize", axi.awsize, 3'b010);
    chk("aw_awburst", axi.awburst, 2'b01);
    chk("aw_early_wvalid", axi.wvalid, 0);
    chk("aw_early_d_wready", d_wready, 0);
    chk("aw_d_awready_wait", d_awready, 0);
    tick();
    chk("aw_early_wvalid2", axi.wvalid, 0);
    axi.awready = 1;
    #1 chk("aw_d_awready", d_awready, 1);
    tick();
    d_awvalid = 0; axi.awready = 0;

    // overlapped 8-beat writeback (wready toggling) and 8-beat d refill
    wbeat = 0; rbeat = 0; rv_seen = 0; wb_seen = 0; wl_seen = 0;
    for (int c = 0; c < 20; c++) begin
      axi.wready = c[0];
      d_wvalid = (wbeat < 8); d_wdata = 32'hD000_0000 + wbeat; d_wlast = (wbeat == 7);
      axi.rvalid = (rbeat < 8); axi.rdata = 32'hA000_0000 + rbeat; axi.rlast = (rbeat == 7);
      #1;
      if (wbeat < 8) begin
        chk("wb_wvalid", axi.wvalid, 1);
        chk("wb_wid", axi.wid, 1);
        chk("wb_wdata", axi.wdata, 32'hD000_0000 + wbeat);
        chk("wb_wlast", axi.wlast, (wbeat == 7));
        chk("wb_wstrb", axi.wstrb, 4'hF);
        chk("wb_d_wready", d_wready, c[0]);
      end
      if (rbeat < 8) begin
        chk("dr_d_rvalid", d_rvalid, 1);
        chk("dr_i_rvalid", i_rvalid, 0);
        chk("dr_d_rdata", d_rdata, 32'hA000_0000 + rbeat);
      end
      if (axi.wvalid && axi.wready) wb_seen++;
      if (axi.wvalid && axi.wready && axi.wlast) wl_seen++;
      if (d_rvalid) rv_seen++;
      tick();
      if (wbeat < 8 && c[0]) wbeat++;
      if (rbeat < 8) rbeat++;
    end
    axi.rvalid = 0; axi.rlast = 0;
    chk("dr_beats", rv_seen, 8);
    chk("wb_beats", wb_seen, 8);
    chk("wb_wlast_count", wl_seen, 1);
    chk("dr_back_idle", axi.arvalid, 0);

    // B response; AW/W forced low in W_RESP
    d_awvalid = 1; d_wvalid = 1; axi.wready = 1; axi.bvalid = 1; d_bready = 0;
    #1 chk("resp_wvalid", axi.wvalid, 0);
    chk("resp_d_wready", d_wready, 0);
    chk("resp_awvalid", axi.awvalid, 0);
    chk("resp_d_bvalid", d_bvalid, 1);
    chk("resp_bready_wait", axi.bready, 0);
    d_bready = 1;
    #1 chk("resp_bready", axi.bready, 1);
    tick();
    chk("widle_d_bvalid", d_bvalid, 0);
    chk("widle_awvalid", axi.awvalid, 1);
    d_awvalid = 0; d_wvalid = 0; axi.bvalid = 0; d_bready = 0; axi.wready = 0;

    // reset mid d burst after 3 beats
    d_arvalid = 1; d_araddr = 32'h0000_5000; d_arlen = 8'd7;
    tick();
    axi.arready = 1;
    #1 chk("rstb_arid", axi.arid, 1);
    tick();
    d_arvalid = 0; axi.arready = 0;
    for (int k = 0; k < 3; k++) begin
      axi.rvalid = 1; axi.rdata = k; axi.rlast = 0; d_rready = 1;
      #1 chk("rstb_beat", d_rvalid, 1);
      tick();
    end
    #1 chk("rstb_beat3", d_rvalid, 1);
    resetn = 1'b0;
    #1 chk("rstb_arvalid", axi.arvalid, 0);
    chk("rstb_rready", axi.rready, 0);
    chk("rstb_d_rvalid", d_rvalid, 0);
    chk("rstb_i_rvalid", i_rvalid, 0);
    tick();
    tick();
    axi.rvalid = 0; resetn = 1'b1;

    // fresh tie after reset: last_d cleared, so d wins again
    i_arvalid = 1; i_araddr = 32'h0000_6000; i_arlen = 8'd0;
    d_arvalid = 1; d_araddr = 32'h0000_7000; d_arlen = 8'd0;
    tick();
    chk("post_arvalid", axi.arvalid, 1);
    chk("post_arid", axi.arid, 1);
    chk("post_araddr", axi.araddr, 32'h0000_7000);
    axi.arready = 1;
    tick();
    d_arvalid = 0; axi.arready = 0;
    axi.rvalid = 1; axi.rlast = 1; d_rready = 1;
    #1 chk("post_d_rvalid", d_rvalid, 1);
    chk("post_i_rvalid", i_rvalid, 0);
    tick();
    axi.rvalid = 0; axi.rlast = 0;
    tick();
    chk("post_i_grant_arid", axi.arid, 0);
    chk("post_i_grant_araddr", axi.araddr, 32'h0000_6000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
